// File: rtl/uart_tx_feeder.sv
// Byte FIFO and busy-handshake feeder in front of transmitter_core.
// Ports: clk/reset, wr_en/wr_data/clear_error in, full/empty/count/overflow out, busy in, start_transmission/parallel_data out.
module uart_tx_feeder #(
  parameter int NO_OF_DATABITS  = 8,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [NO_OF_DATABITS-1:0]  wr_data,
  input  logic                       clear_error,
  output logic                       full,
  output logic                       empty,
  output logic [FIFO_DEPTH_LOG2:0]   count,
  output logic                       overflow,
  input  logic                       busy,
  output logic                       start_transmission,
  output logic [NO_OF_DATABITS-1:0]  parallel_data
);

  localparam int DW    = NO_OF_DATABITS;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          start_q, start_d;
  logic [DW-1:0] pdata_q, pdata_d;
  state_e        state_q, state_d;

  logic wr_acc;
  logic drop;
  logic pop;

  assign wr_acc = wr_en & ~full_q;
  assign drop   = wr_en & full_q;

  // FSM: pop only from IDLE, start held through LOAD and WAIT_BUSY
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // start is registered from the next state so it is glitch-free
  assign start_d = (state_d == LOAD) | (state_d == WAIT_BUSY);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pdata_d  = pdata_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      pdata_d  = mem_q[rd_ptr_q];
    end
    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  assign full_d  = (count_d == CNT_FULL);
  assign empty_d = (count_d == '0);

  // a dropped write outranks a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_error) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      pdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      start_q  <= start_d;
      pdata_q  <= pdata_d;
    end
  end

  assign full               = full_q;
  assign empty              = empty_q;
  assign count              = count_q;
  assign overflow           = ovf_q;
  assign start_transmission = start_q;
  assign parallel_data      = pdata_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder.
// Directed table, corner sequences and random traffic against a queue model.
module tb_uart_tx_feeder;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clear_error;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       start_transmission;
  logic [7:0] parallel_data;

  uart_tx_feeder #(
    .NO_OF_DATABITS (8),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .clear_error       (clear_error),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .overflow          (overflow),
    .busy              (busy),
    .start_transmission(start_transmission),
    .parallel_data     (parallel_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // reference model: queue of accepted bytes plus handshake bookkeeping
  logic [7:0] mq[$];
  logic       m_inflight;
  logic       m_acked;
  int         m_age;
  logic       m_ovf;
  logic [7:0] m_pd;

  logic [7:0] emitted[$];
  logic       prev_st;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       clr;
    logic       bz;
    logic [4:0] cnt;
    logic       emp;
    logic       st;
    logic [7:0] pd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_inflight = 1'b0;
    m_acked    = 1'b0;
    m_age      = 0;
    m_ovf      = 1'b0;
    m_pd       = 8'h00;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] wd,
                            input logic clr, input logic bz);
    int old_size;
    old_size = mq.size();
    if (!m_inflight) begin
      if (old_size > 0) begin
        m_pd       = mq.pop_front();
        m_inflight = 1'b1;
        m_acked    = 1'b0;
        m_age      = 0;
      end
    end else begin
      if (m_age >= 1 && !m_acked && bz) begin
        m_acked = 1'b1;
      end else if (m_acked && !bz) begin
        m_inflight = 1'b0;
      end
      m_age++;
    end
    if (we && old_size < 16) begin
      mq.push_back(wd);
    end
    if (we && old_size == 16) begin
      m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic model_cmp();
    int sz;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == 16));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("start", 32'(start_transmission), 32'(m_inflight && !m_acked));
    chk("parallel_data", 32'(parallel_data), 32'(m_pd));
  endtask

  task automatic step(input logic we, input logic [7:0] wd,
                      input logic clr, input logic bz);
    wr_en       = we;
    wr_data     = wd;
    clear_error = clr;
    busy        = bz;
    @(posedge clk);
    model_edge(we, wd, clr, bz);
    #1;
    model_cmp();
    if (start_transmission && !prev_st) begin
      emitted.push_back(parallel_data);
    end
    prev_st = start_transmission;
  endtask

  task automatic do_reset(input int n);
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    clear_error = 1'b0;
    busy        = 1'b0;
    reset       = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    prev_st = 1'b0;
  endtask

  // transmitter stand-in: busy for 5 cycles once start is seen
  task automatic drain(input int nbytes, input string nm);
    int   tx_cnt;
    int   cyc;
    int   post;
    logic bz;
    tx_cnt = 0;
    cyc    = 0;
    post   = 0;
    while (cyc < 600 && post < 12) begin
      if (tx_cnt > 0) begin
        bz = 1'b1;
        tx_cnt--;
      end else if (start_transmission) begin
        bz     = 1'b1;
        tx_cnt = 4;
      end else begin
        bz = 1'b0;
      end
      step(1'b0, 8'h00, 1'b0, bz);
      cyc++;
      if (emitted.size() >= nbytes) post++;
    end
    chk(nm, 32'(emitted.size()), 32'(nbytes));
  endtask

  initial begin
    logic bzr;
    n_assert = 0;
    n_fail   = 0;
    prev_st  = 1'b0;
    reset    = 1'b1;

    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5};
    vecs[6]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'h5A};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'h5A};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h5A};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h5A};

    // reset and idle
    do_reset(5);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_start", 32'(start_transmission), 32'd0);
    chk("rst_pdata", 32'(parallel_data), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_no_start", 32'(emitted.size()), 32'd0);

    // directed single-byte table
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].clr, vecs[i].bz);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("vec%0d_start", i), 32'(start_transmission),
          32'(vecs[i].st));
      chk($sformatf("vec%0d_pdata", i), 32'(parallel_data),
          32'(vecs[i].pd));
    end

    // fill and overflow behind a stuck transmitter
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1);
      if (i == 15) begin
        chk("full_after_16", 32'(full), 32'd1);
        chk("ovf_before_drop", 32'(overflow), 32'd0);
      end
    end
    chk("count_full", 32'(count), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    emitted.delete();
    drain(16, "drain_fill");
    for (int k = 0; k < 16; k++) begin
      if (k < emitted.size()) begin
        chk($sformatf("drain_byte%0d", k), 32'(emitted[k]), 32'(k));
      end
    end

    // write and pop in the same cycle
    emitted.delete();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    chk("wr_pop_count", 32'(count), 32'd1);
    drain(2, "drain_pair");
    if (emitted.size() == 2) begin
      chk("pair_first", 32'(emitted[0]), 32'h11);
      chk("pair_second", 32'(emitted[1]), 32'h22);
    end

    // reset during WAIT_DONE
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_start", 32'(start_transmission), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    prev_st = 1'b0;
    emitted.delete();
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_silent", 32'(emitted.size()), 32'd0);

    // randomized traffic
    bzr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) bzr = ~bzr;
      step(1'($urandom_range(1)), 8'($urandom),
           1'($urandom_range(9) == 0), bzr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
